// File: rtl/fifo_wr_ctrl_if.sv
// rtl/fifo_wr_ctrl_if.sv - producer-side handshake and status bundle for the FIFO write controller
interface fifo_wr_ctrl_if #(
    parameter int ADDR_WIDTH = 3
);
    logic                  inc;
    logic [ADDR_WIDTH:0]   rptr_gray;
    logic                  clr_ovf;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [ADDR_WIDTH:0]   wptr_gray;
    logic                  full;
    logic                  almost_full;
    logic [ADDR_WIDTH:0]   wlevel;
    logic                  overflow;

    modport master (
        output inc, rptr_gray, clr_ovf,
        input  wr_en, waddr, wptr_gray, full, almost_full, wlevel, overflow
    );

    modport slave (
        input  inc, rptr_gray, clr_ovf,
        output wr_en, waddr, wptr_gray, full, almost_full, wlevel, overflow
    );
endinterface

// File: rtl/fifo_wr_ctrl.sv
// rtl/fifo_wr_ctrl.sv - async FIFO write-side controller: write pointer, Gray export, read-pointer sync, status flags
module fifo_wr_ctrl #(
    parameter int ADDR_WIDTH  = 3,
    parameter int SYNC_STAGES = 2,
    parameter int AF_LEVEL    = 6
) (
    input  logic           clk,
    input  logic           rst,
    fifo_wr_ctrl_if.slave  bus
);
    localparam int AW = ADDR_WIDTH;
    localparam logic [AW:0] AF_THRESH = (AW+1)'(AF_LEVEL);

    logic [AW:0]                  r_wptr;
    logic [AW:0]                  r_wptr_gray;
    logic [SYNC_STAGES-1:0][AW:0] r_sync;
    logic                         r_overflow;

    logic [AW:0] w_wptr_next;
    logic [AW:0] w_rq;
    logic [AW:0] w_rbin;
    logic [AW:0] w_wlevel;
    logic        w_full;
    logic        w_wr_en;

    assign w_wr_en     = bus.inc & ~w_full;
    assign w_wptr_next = r_wptr + {{AW{1'b0}}, w_wr_en};
    assign w_rq        = r_sync[SYNC_STAGES-1];

    // Full when the writer is exactly one lap ahead of the synchronised reader.
    assign w_full = (r_wptr_gray == {~w_rq[AW:AW-1], w_rq[AW-2:0]});

    always_comb begin
        w_rbin = '0;
        for (int i = 0; i <= AW; i++) begin
            w_rbin[i] = ^(w_rq >> i);
        end
    end

    assign w_wlevel = r_wptr - w_rbin;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr      <= '0;
            r_wptr_gray <= '0;
        end else begin
            r_wptr      <= w_wptr_next;
            r_wptr_gray <= w_wptr_next ^ (w_wptr_next >> 1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync[0] <= bus.rptr_gray;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    // A rejected write in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (bus.inc && w_full) begin
            r_overflow <= 1'b1;
        end else if (bus.clr_ovf) begin
            r_overflow <= 1'b0;
        end
    end

    assign bus.wr_en       = w_wr_en;
    assign bus.waddr       = r_wptr[AW-1:0];
    assign bus.wptr_gray   = r_wptr_gray;
    assign bus.full        = w_full;
    assign bus.almost_full = (w_wlevel >= AF_THRESH);
    assign bus.wlevel      = w_wlevel;
    assign bus.overflow    = r_overflow;
endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// tb/tb_fifo_wr_ctrl.sv - self-checking bench for fifo_wr_ctrl against a count-based occupancy model
module tb_fifo_wr_ctrl;
    localparam int AW    = 3;
    localparam int DEPTH = 8;
    localparam int SPAN  = 16;
    localparam int SYNC  = 2;
    localparam int AFL   = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   rd  = 0;
    int   checks = 0;
    int   passed = 0;

    fifo_wr_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

    fifo_wr_ctrl #(.ADDR_WIDTH(AW), .SYNC_STAGES(SYNC), .AF_LEVEL(AFL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic int gray(input int x);
        return (x ^ (x >> 1)) & (SPAN - 1);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Model: writes counted, reader position seen SYNC edges late.
    int m_w = 0;
    int m_vis = 0;
    int m_q[$];
    bit m_ovf = 0;
    bit m_f;

    function automatic int m_lvl();
        return ((m_w - m_vis) % SPAN + SPAN) % SPAN;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_w = 0; m_vis = 0; m_q.delete(); m_ovf = 0;
        end else begin
            m_f = (m_lvl() == DEPTH);
            if (bus.inc && m_f) m_ovf = 1;
            else if (bus.clr_ovf) m_ovf = 0;
            if (bus.inc && !m_f) m_w++;
            m_q.push_back(rd % SPAN);
            if (m_q.size() > SYNC) void'(m_q.pop_front());
            m_vis = (m_q.size() == SYNC) ? m_q[0] : 0;
        end
    end

    always @(negedge clk) begin
        check("m_wlevel", int'(bus.wlevel), m_lvl());
        check("m_full", int'(bus.full), int'(m_lvl() == DEPTH));
        check("m_almost_full", int'(bus.almost_full), int'(m_lvl() >= AFL));
        check("m_waddr", int'(bus.waddr), m_w % DEPTH);
        check("m_wptr_gray", int'(bus.wptr_gray), gray(m_w % SPAN));
        check("m_wr_en", int'(bus.wr_en), int'(bus.inc && (m_lvl() != DEPTH)));
        check("m_overflow", int'(bus.overflow), int'(m_ovf));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input int v);
        rd = v;
        bus.rptr_gray = (AW+1)'(gray(v % SPAN));
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW:0] prev;
        bus.inc = 1'b0; bus.clr_ovf = 1'b0; set_rd(0);
        repeat (2) step();
        check("rst_wptr_gray", int'(bus.wptr_gray), 0);
        check("rst_wlevel", int'(bus.wlevel), 0);
        check("rst_full", int'(bus.full), 0);
        check("rst_af", int'(bus.almost_full), 0);
        check("rst_ovf", int'(bus.overflow), 0);
        check("rst_waddr", int'(bus.waddr), 0);
        check("rst_wr_en", int'(bus.wr_en), 0);
        rst = 1'b0;
        step();

        bus.inc = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step();
            if (i == 5) check("af_after5", int'(bus.almost_full), 0);
            if (i == 6) check("af_after6", int'(bus.almost_full), 1);
            if (i == 7) check("full_after7", int'(bus.full), 0);
        end
        check("fill_full", int'(bus.full), 1);
        check("fill_gray", int'(bus.wptr_gray), 4'b1100);
        check("fill_wlevel", int'(bus.wlevel), 8);
        check("fill_waddr", int'(bus.waddr), 0);
        check("fill_wr_en", int'(bus.wr_en), 0);
        step();
        check("ovf_set", int'(bus.overflow), 1);
        check("ovf_gray_hold", int'(bus.wptr_gray), 4'b1100);
        bus.clr_ovf = 1'b1;
        step();
        check("ovf_set_wins", int'(bus.overflow), 1);
        bus.inc = 1'b0;
        step();
        check("ovf_cleared", int'(bus.overflow), 0);
        bus.clr_ovf = 1'b0;

        set_rd(1);
        step();
        check("rd_full_edge1", int'(bus.full), 1);
        step();
        check("rd_full_edge2", int'(bus.full), 0);
        check("rd_wlevel", int'(bus.wlevel), 7);
        check("rd_af", int'(bus.almost_full), 1);

        rst = 1'b1; set_rd(0);
        step();
        rst = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            prev = bus.wptr_gray;
            bus.inc = 1'b1;
            step();
            check("wrap_one_bit", $countones(prev ^ bus.wptr_gray), 1);
            bus.inc = 1'b0;
            set_rd(i);
            step();
        end
        check("wrap_gray_zero", int'(bus.wptr_gray), 0);

        bus.inc = 1'b1;
        repeat (3) step();
        bus.inc = 1'b0;
        check("pre_pulse_waddr", int'(bus.waddr), 3);
        #1 rst = 1'b1;
        #1;
        check("pulse_gray", int'(bus.wptr_gray), 0);
        check("pulse_wlevel", int'(bus.wlevel), 0);
        check("pulse_ovf", int'(bus.overflow), 0);
        rst = 1'b0;
        bus.inc = 1'b1;
        #1;
        check("post_pulse_wr_en", int'(bus.wr_en), 1);
        check("post_pulse_waddr", int'(bus.waddr), 0);
        step();
        check("post_pulse_next", int'(bus.waddr), 1);
        bus.inc = 1'b0;
        step();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
